// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the multi-port SDRAM front end.
//   sdram_cmd_t : one command word as handed to the controller FIFO
//   ROW_MSB/LSB : row field position inside the 25-bit address
//   port_w()    : width of a requester index (tag width)
//   row_of()    : extract the row field from an address
package sdram_arb_pkg;

    localparam int ROW_MSB = 24;
    localparam int ROW_LSB = 10;
    localparam int ROW_W   = ROW_MSB - ROW_LSB + 1;

    typedef struct packed {
        logic        is_write;
        logic [1:0]  mask;
        logic [24:0] addr;
        logic [15:0] data;
    } sdram_cmd_t;

    // Tag width for a given port count; never narrower than one bit.
    function automatic int port_w(input int nports);
        if (nports <= 2) begin
            return 1;
        end else begin
            return $clog2(nports);
        end
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [24:0] addr);
        return addr[ROW_MSB:ROW_LSB];
    endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// Outstanding-read tag FIFO. Each entry is the index of the port that issued
// a read; the controller returns reads in order, so the head is always the
// owner of the next sd_readValid.
//   push_i/push_data_i : enqueue a tag
//   pop_i              : dequeue (ignored while empty)
//   head_o             : current head tag
//   empty_o / full_o   : registered occupancy flags
// Simultaneous push and pop is legal and leaves occupancy unchanged.
module sdram_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             push_ok_s, pop_ok_s;

    // Next-state pointers and occupancy; a pop frees a slot for a same-cycle push.
    always_comb begin
        push_ok_s = push_i & (~full_q | pop_i);
        pop_ok_s  = pop_i & ~empty_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        empty_d = (count_d == CNT_ZERO);
        full_d  = (count_d == CNT_FULL);
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Tag storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multi-port front end for the EasySDRAM command FIFO.
// Round-robin arbitration with row affinity: the last winner keeps the bus
// while it stays on the same row, for at most MAX_BURST consecutive grants.
// Reads are tagged with the requester index and in-order returns are routed
// back to the owning port one cycle later.
//   req_*           : per-port command, held until gnt_o
//   gnt_o           : one-hot accept strobe (combinational)
//   sd_*            : command word / handshake to and from the controller
//   rsp_*           : registered read-return bus with one-hot valid
//   tag_full_o      : reads blocked, tag FIFO full
//   err_mask_o      : sticky, an illegal-mask write was dropped
//   err_tag_o       : sticky, a read return arrived with no tag outstanding
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS    = 4,
    parameter int TAG_DEPTH = 512,
    parameter int MAX_BURST = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORTS-1:0]       req_i,
    input  logic [NPORTS-1:0]       req_is_write_i,
    input  logic [NPORTS-1:0][24:0] req_addr_i,
    input  logic [NPORTS-1:0][1:0]  req_mask_i,
    input  logic [NPORTS-1:0][15:0] req_data_i,
    output logic [NPORTS-1:0]       gnt_o,
    output logic                    sd_write_o,
    input  logic                    sd_full_i,
    output logic                    sd_is_write_o,
    output logic [24:0]             sd_address_o,
    output logic [1:0]              sd_write_mask_o,
    output logic [15:0]             sd_write_data_o,
    output logic                    sd_keep_open_o,
    input  logic                    sd_read_valid_i,
    input  logic [24:0]             sd_raddr_i,
    input  logic [15:0]             sd_rdata_i,
    output logic [NPORTS-1:0]       rsp_valid_o,
    output logic [24:0]             rsp_addr_o,
    output logic [15:0]             rsp_data_o,
    output logic                    tag_full_o,
    output logic                    err_mask_o,
    output logic                    err_tag_o
);

    localparam int PW = port_w(NPORTS);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_ONE   = BW'(1);
    localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);
    localparam logic [PW-1:0] LAST_RESET  = PW'(NPORTS - 1);

    // Arbitration state
    logic [PW-1:0]    last_q, last_d;
    logic [ROW_W-1:0] last_row_q, last_row_d;
    logic             last_row_valid_q, last_row_valid_d;
    logic [BW-1:0]    burst_cnt_q, burst_cnt_d;

    // Response and error state
    logic [NPORTS-1:0] rsp_valid_q, rsp_valid_d;
    logic [24:0]       rsp_addr_q, rsp_addr_d;
    logic [15:0]       rsp_data_q, rsp_data_d;
    logic              err_mask_q, err_mask_d;
    logic              err_tag_q, err_tag_d;

    // Combinational arbitration signals
    logic [NPORTS-1:0] elig_s;
    logic              any_s;
    logic              affinity_s;
    logic              rr_found_s;
    logic [PW-1:0]     rr_win_s;
    logic [PW-1:0]     idx_s;
    logic [PW-1:0]     win_s;
    sdram_cmd_t        cmd_s;
    logic              illegal_s;
    logic              issue_s;
    logic              push_s;

    // Tag FIFO interface
    logic [PW-1:0] tag_head_s;
    logic          tag_empty_s;
    logic          tag_full_s;

    sdram_tag_fifo #(
        .WIDTH (PW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i (win_s),
        .pop_i       (sd_read_valid_i),
        .head_o      (tag_head_s),
        .empty_o     (tag_empty_s),
        .full_o      (tag_full_s)
    );

    // Eligibility, affinity check and rotating priority scan starting after last winner.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NPORTS; i++) begin
            elig_s[i] = req_i[i] & (req_is_write_i[i] | ~tag_full_s) & ~sd_full_i & ~rst;
        end
        any_s = |elig_s;

        affinity_s = elig_s[last_q] & last_row_valid_q
                   & (row_of(req_addr_i[last_q]) == last_row_q)
                   & (burst_cnt_q < BURST_LIMIT);

        rr_found_s = 1'b0;
        rr_win_s   = last_q;
        idx_s      = last_q;
        for (int k = 1; k <= NPORTS; k++) begin
            idx_s = PW'((int'(last_q) + k) % NPORTS);
            if (!rr_found_s && elig_s[idx_s]) begin
                rr_found_s = 1'b1;
                rr_win_s   = idx_s;
            end else begin
                rr_found_s = rr_found_s;
            end
        end

        if (affinity_s) begin
            win_s = last_q;
        end else begin
            win_s = rr_win_s;
        end

        cmd_s.is_write = req_is_write_i[win_s];
        cmd_s.mask     = req_mask_i[win_s];
        cmd_s.addr     = req_addr_i[win_s];
        cmd_s.data     = req_data_i[win_s];

        // An all-zero mask write is accepted (gnt) but never forwarded.
        illegal_s = any_s & cmd_s.is_write & (cmd_s.mask == 2'b00);
        issue_s   = any_s & ~illegal_s;
        push_s    = issue_s & ~cmd_s.is_write;

        gnt_o = '0;
        for (int i = 0; i < NPORTS; i++) begin
            gnt_o[i] = any_s & (win_s == PW'(i));
        end
    end

    assign sd_write_o      = issue_s;
    assign sd_is_write_o   = cmd_s.is_write;
    assign sd_address_o    = cmd_s.addr;
    assign sd_write_mask_o = cmd_s.mask;
    assign sd_write_data_o = cmd_s.data;
    assign sd_keep_open_o  = |req_i;

    // Next-state for arbitration bookkeeping, read-return routing and sticky errors.
    always_comb begin
        last_d           = last_q;
        last_row_d       = last_row_q;
        last_row_valid_d = last_row_valid_q;
        burst_cnt_d      = burst_cnt_q;
        err_mask_d       = err_mask_q | illegal_s;
        err_tag_d        = err_tag_q;
        rsp_valid_d      = '0;
        rsp_addr_d       = rsp_addr_q;
        rsp_data_d       = rsp_data_q;

        if (issue_s) begin
            last_d           = win_s;
            last_row_d       = row_of(cmd_s.addr);
            last_row_valid_d = 1'b1;
            if (win_s == last_q) begin
                // Saturate: once at the limit the affinity test already fails.
                if (burst_cnt_q < BURST_LIMIT) begin
                    burst_cnt_d = burst_cnt_q + BURST_ONE;
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
            end else begin
                burst_cnt_d = BURST_ONE;
            end
        end else begin
            last_d = last_q;
        end

        if (sd_read_valid_i) begin
            if (tag_empty_s) begin
                err_tag_d = 1'b1;
            end else begin
                for (int i = 0; i < NPORTS; i++) begin
                    rsp_valid_d[i] = (tag_head_s == PW'(i));
                end
                rsp_addr_d = sd_raddr_i;
                rsp_data_d = sd_rdata_i;
            end
        end else begin
            rsp_valid_d = '0;
        end
    end

    // State registers; reset leaves port NPORTS-1 as last winner so port 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q           <= LAST_RESET;
            last_row_q       <= '0;
            last_row_valid_q <= 1'b0;
            burst_cnt_q      <= '0;
            rsp_valid_q      <= '0;
            rsp_addr_q       <= '0;
            rsp_data_q       <= '0;
            err_mask_q       <= 1'b0;
            err_tag_q        <= 1'b0;
        end else begin
            last_q           <= last_d;
            last_row_q       <= last_row_d;
            last_row_valid_q <= last_row_valid_d;
            burst_cnt_q      <= burst_cnt_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_addr_q       <= rsp_addr_d;
            rsp_data_q       <= rsp_data_d;
            err_mask_q       <= err_mask_d;
            err_tag_q        <= err_tag_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_addr_o  = rsp_addr_q;
    assign rsp_data_o  = rsp_data_q;
    assign tag_full_o  = tag_full_s;
    assign err_mask_o  = err_mask_q;
    assign err_tag_o   = err_tag_q;

endmodule
